// File: rtl/weight_bank.sv
// rtl/weight_bank.sv - multi-layer square weight store with row/column reads, write bypass and sequenced layer clear
module weight_bank #(
    parameter int size      = 3,
    parameter int data_size = 16,
    parameter int max_layer = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      write_valid,
    output logic                      write_ready,
    input  logic [31:0]               write_layer_index,
    input  logic [31:0]               write_row_index,
    input  logic [data_size*size-1:0] write_data,
    input  logic                      read_valid,
    output logic                      read_ready,
    input  logic                      read_mode,
    input  logic [31:0]               read_layer_index,
    input  logic [31:0]               read_index,
    output logic [data_size*size-1:0] read_data,
    output logic                      read_out_valid,
    output logic                      read_error,
    input  logic                      clear_valid,
    input  logic [31:0]               clear_layer_index,
    output logic                      busy
);
    localparam int LW = (max_layer > 1) ? $clog2(max_layer) : 1;
    localparam int RW = (size > 1) ? $clog2(size) : 1;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t         state, state_next;
    logic [LW-1:0]  clr_layer, clr_layer_next;
    logic [RW-1:0]  clr_row, clr_row_next;

    logic [data_size*size-1:0] mem [max_layer][size];

    logic           wr_accept, wr_in_range, rd_accept, rd_in_range, byp_layer, clear_start;
    logic [LW-1:0]  wr_layer, rd_layer;
    logic [RW-1:0]  wr_row, rd_idx;
    logic [data_size*size-1:0] rd_vec;
    int             col_base;

    assign wr_in_range = (write_layer_index < 32'(max_layer)) && (write_row_index < 32'(size));
    assign rd_in_range = (read_layer_index < 32'(max_layer)) && (read_index < 32'(size));
    assign wr_layer    = write_layer_index[LW-1:0];
    assign wr_row      = write_row_index[RW-1:0];
    assign rd_layer    = read_layer_index[LW-1:0];
    assign rd_idx      = read_index[RW-1:0];
    assign wr_accept   = write_valid && write_ready;
    assign rd_accept   = read_valid && read_ready;
    assign clear_start = clear_valid && (state == IDLE) && (clear_layer_index < 32'(max_layer));
    assign byp_layer   = wr_accept && wr_in_range && (wr_layer == rd_layer);

    always_comb begin
        state_next     = state;
        clr_layer_next = clr_layer;
        clr_row_next   = clr_row;
        write_ready    = (state == IDLE) && !clear_valid;
        read_ready     = (state == IDLE) && !clear_valid;
        busy           = (state == CLEAR);
        case (state)
            IDLE: begin
                if (clear_start) begin
                    state_next     = CLEAR;
                    clr_layer_next = clear_layer_index[LW-1:0];
                    clr_row_next   = '0;
                end
            end
            CLEAR: begin
                if (clr_row == RW'(size - 1)) state_next = IDLE;
                else clr_row_next = clr_row + 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            clr_layer <= '0;
            clr_row   <= '0;
        end else begin
            state     <= state_next;
            clr_layer <= clr_layer_next;
            clr_row   <= clr_row_next;
        end
    end

    // Reset blocks array updates so an interrupted clear leaves untouched rows intact.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (wr_accept && wr_in_range) mem[wr_layer][wr_row] <= write_data;
            if (state == CLEAR) mem[clr_layer][clr_row] <= '0;
        end
    end

    always_comb begin
        rd_vec   = '0;
        col_base = (size - 1 - int'(rd_idx)) * data_size;
        if (rd_in_range) begin
            if (!read_mode) begin
                rd_vec = mem[rd_layer][rd_idx];
                if (byp_layer && (wr_row == rd_idx)) rd_vec = write_data;
            end else begin
                for (int i = 0; i < size; i++) begin
                    rd_vec[(size-1-i)*data_size +: data_size] = mem[rd_layer][RW'(i)][col_base +: data_size];
                    if (byp_layer && (wr_row == RW'(i)))
                        rd_vec[(size-1-i)*data_size +: data_size] = write_data[col_base +: data_size];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            read_data      <= '0;
            read_out_valid <= 1'b0;
            read_error     <= 1'b0;
        end else begin
            read_out_valid <= rd_accept;
            if (rd_accept) begin
                read_data  <= rd_vec;
                read_error <= !rd_in_range;
            end
        end
    end
endmodule

// File: tb/tb_weight_bank.sv
// tb/tb_weight_bank.sv - randomized self-checking bench for weight_bank against an element-level model
module tb_weight_bank;
    localparam int S = 3;
    localparam int D = 16;
    localparam int L = 5;

    logic           clk = 1'b0;
    logic           reset;
    logic           write_valid, write_ready;
    logic [31:0]    write_layer_index, write_row_index;
    logic [D*S-1:0] write_data;
    logic           read_valid, read_ready, read_mode;
    logic [31:0]    read_layer_index, read_index;
    logic [D*S-1:0] read_data;
    logic           read_out_valid, read_error;
    logic           clear_valid;
    logic [31:0]    clear_layer_index;
    logic           busy;

    int tests = 0;
    int fails = 0;

    logic [D-1:0]   m [L][S][S];
    logic [D*S-1:0] exp_vec;
    logic           exp_err;

    weight_bank #(.size(S), .data_size(D), .max_layer(L)) dut (
        .clk(clk), .reset(reset),
        .write_valid(write_valid), .write_ready(write_ready),
        .write_layer_index(write_layer_index), .write_row_index(write_row_index),
        .write_data(write_data),
        .read_valid(read_valid), .read_ready(read_ready), .read_mode(read_mode),
        .read_layer_index(read_layer_index), .read_index(read_index),
        .read_data(read_data), .read_out_valid(read_out_valid), .read_error(read_error),
        .clear_valid(clear_valid), .clear_layer_index(clear_layer_index), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [D*S-1:0] pack3(input logic [D-1:0] a, input logic [D-1:0] b, input logic [D-1:0] c);
        return {a, b, c};
    endfunction

    function automatic logic [D*S-1:0] model_read(input int l, input bit mode, input int idx);
        logic [D*S-1:0] v;
        v = '0;
        if (l < L && idx < S)
            for (int e = 0; e < S; e++)
                v[(S-e)*D-1 -: D] = mode ? m[l][e][idx] : m[l][idx][e];
        return v;
    endfunction

    task automatic model_write(input int l, input int r, input logic [D*S-1:0] d);
        if (l < L && r < S)
            for (int e = 0; e < S; e++) m[l][r][e] = d[(S-e)*D-1 -: D];
    endtask

    task automatic idle_inputs();
        write_valid = 0; write_layer_index = 0; write_row_index = 0; write_data = '0;
        read_valid = 0; read_mode = 0; read_layer_index = 0; read_index = 0;
        clear_valid = 0; clear_layer_index = 0;
    endtask

    // One cycle with no clear pending; the model sees the write first so same-edge reads get post-write data.
    task automatic op(input bit wv, input int wl, input int wr, input logic [D*S-1:0] wd,
                      input bit rv, input bit rm, input int rl, input int ri);
        write_valid = wv; write_layer_index = 32'(wl); write_row_index = 32'(wr); write_data = wd;
        read_valid = rv; read_mode = rm; read_layer_index = 32'(rl); read_index = 32'(ri);
        if (wv) model_write(wl, wr, wd);
        exp_vec = model_read(rl, rm, ri);
        exp_err = !(rl < L && ri < S);
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (read_out_valid !== 1'b0) begin fails++; $display("FAIL reset_rov got %b want 0", read_out_valid); end
        tests++; if (read_data !== '0) begin fails++; $display("FAIL reset_data got %h want 0", read_data); end
        tests++; if (read_error !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL reset_err_busy got %b%b want 00", read_error, busy); end
        tests++; if (write_ready !== 1'b1 || read_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b%b want 11", write_ready, read_ready); end
        reset = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_fill();
        for (int l = 0; l < L; l++)
            for (int r = 0; r < S; r++)
                op(1, l, r, {16'($urandom), 16'($urandom), 16'($urandom)}, 0, 0, 0, 0);
        for (int l = 0; l < L; l++)
            for (int r = 0; r < S; r++) begin
                op(0, 0, 0, '0, 1, 0, l, r);
                tests++; if (read_data !== exp_vec) begin fails++; $display("FAIL fill_readback l%0d r%0d got %h want %h", l, r, read_data, exp_vec); end
            end
    endtask

    task automatic test_row_read();
        op(1, 2, 1, pack3(16'h1, 16'h2, 16'h3), 0, 0, 0, 0);
        op(0, 0, 0, '0, 1, 0, 2, 1);
        tests++;
        if (read_out_valid !== 1'b1 || read_data !== 48'h000100020003 || read_error !== 1'b0) begin
            fails++; $display("FAIL row_read got v%b %h e%b want v1 000100020003 e0", read_out_valid, read_data, read_error);
        end
    endtask

    task automatic test_column();
        for (int r = 0; r < S; r++)
            op(1, 0, r, pack3(16'(3*r+1), 16'(3*r+2), 16'(3*r+3)), 0, 0, 0, 0);
        op(0, 0, 0, '0, 1, 1, 0, 2);
        tests++; if (read_data !== pack3(16'd3, 16'd6, 16'd9)) begin fails++; $display("FAIL col_read got %h want 000300060009", read_data); end
        op(1, 0, 0, pack3(16'd10, 16'd11, 16'd12), 1, 1, 0, 2);
        tests++; if (read_data !== pack3(16'd12, 16'd6, 16'd9) || read_out_valid !== 1'b1) begin
            fails++; $display("FAIL col_bypass got %h want 000c00060009", read_data);
        end
    endtask

    task automatic test_bypass_row();
        logic [D*S-1:0] d;
        d = {16'($urandom), 16'($urandom), 16'($urandom)};
        op(1, 4, 2, d, 1, 0, 4, 2);
        tests++; if (read_data !== d) begin fails++; $display("FAIL row_bypass got %h want %h", read_data, d); end
    endtask

    task automatic test_range();
        op(0, 0, 0, '0, 1, 0, 5, 0);
        tests++; if (read_data !== '0 || read_error !== 1'b1) begin fails++; $display("FAIL range_layer got %h e%b want 0 e1", read_data, read_error); end
        op(0, 0, 0, '0, 1, 1, 1, 3);
        tests++; if (read_data !== '0 || read_error !== 1'b1) begin fails++; $display("FAIL range_index got %h e%b want 0 e1", read_data, read_error); end
        op(1, 2, 7, 48'hdeadbeefcafe, 0, 0, 0, 0);
        op(1, 5, 0, 48'h123456789abc, 0, 0, 0, 0);
        for (int r = 0; r < S; r++) begin
            op(0, 0, 0, '0, 1, 0, 2, r);
            tests++; if (read_data !== exp_vec || read_error !== 1'b0) begin fails++; $display("FAIL range_write r%0d got %h want %h", r, read_data, exp_vec); end
        end
        clear_valid = 1; clear_layer_index = 7;
        @(posedge clk); #1;
        idle_inputs();
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL range_clear busy got %b want 0", busy); end
    endtask

    task automatic test_clear();
        int busy_cnt;
        for (int r = 0; r < S; r++)
            op(1, 1, r, {16'($urandom), 16'($urandom), 16'($urandom)}, 0, 0, 0, 0);
        write_valid = 1; write_layer_index = 1; write_row_index = 0; write_data = 48'hffffffffffff;
        read_valid = 1; read_layer_index = 1; read_index = 0;
        clear_valid = 1; clear_layer_index = 1;
        #1;
        tests++; if (write_ready !== 1'b0 || read_ready !== 1'b0) begin fails++; $display("FAIL clear_req_ready got %b%b want 00", write_ready, read_ready); end
        @(posedge clk); #1;
        idle_inputs();
        tests++; if (read_out_valid !== 1'b0) begin fails++; $display("FAIL clear_read_blocked got %b want 0", read_out_valid); end
        busy_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            if (busy === 1'b1) begin
                busy_cnt++;
                tests++; if (write_ready !== 1'b0 || read_ready !== 1'b0) begin fails++; $display("FAIL clear_busy_ready k%0d got %b%b want 00", k, write_ready, read_ready); end
            end
            @(posedge clk); #1;
        end
        tests++; if (busy_cnt != S) begin fails++; $display("FAIL clear_busy_len got %0d want %0d", busy_cnt, S); end
        tests++; if (write_ready !== 1'b1 || read_ready !== 1'b1) begin fails++; $display("FAIL clear_after_ready got %b%b want 11", write_ready, read_ready); end
        for (int r = 0; r < S; r++) for (int e = 0; e < S; e++) m[1][r][e] = '0;
        for (int l = 0; l < 2; l++)
            for (int r = 0; r < S; r++) begin
                op(0, 0, 0, '0, 1, 0, l, r);
                tests++; if (read_data !== exp_vec) begin fails++; $display("FAIL clear_contents l%0d r%0d got %h want %h", l, r, read_data, exp_vec); end
            end
    endtask

    task automatic test_reset_mid_clear();
        for (int r = 0; r < S; r++)
            op(1, 3, r, {16'($urandom), 16'($urandom), 16'($urandom)}, 0, 0, 0, 0);
        clear_valid = 1; clear_layer_index = 3;
        @(posedge clk); #1;
        idle_inputs();
        @(posedge clk); #1;
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        tests++; if (busy !== 1'b0 || read_ready !== 1'b1) begin fails++; $display("FAIL midclear_busy got %b ready %b want 0 1", busy, read_ready); end
        for (int e = 0; e < S; e++) m[3][0][e] = '0;
        for (int r = 0; r < S; r++) begin
            op(0, 0, 0, '0, 1, 0, 3, r);
            tests++; if (read_data !== exp_vec) begin fails++; $display("FAIL midclear_row r%0d got %h want %h", r, read_data, exp_vec); end
        end
    endtask

    task automatic test_random();
        logic [D*S-1:0] held;
        bit rv;
        held = read_data;
        for (int n = 0; n < 300; n++) begin
            rv = 1'($urandom);
            op(1'($urandom), int'($urandom % 6), int'($urandom % 4), {16'($urandom), 16'($urandom), 16'($urandom)},
               rv, 1'($urandom), int'($urandom % 6), int'($urandom % 4));
            tests++;
            if (rv) begin
                if (read_out_valid !== 1'b1 || read_data !== exp_vec || read_error !== exp_err) begin
                    fails++; $display("FAIL random_read n%0d got v%b %h e%b want v1 %h e%b", n, read_out_valid, read_data, read_error, exp_vec, exp_err);
                end
                held = exp_vec;
            end else if (read_out_valid !== 1'b0 || read_data !== held) begin
                fails++; $display("FAIL random_hold n%0d got v%b %h want v0 %h", n, read_out_valid, read_data, held);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_row_read();
        test_column();
        test_bypass_row();
        test_range();
        test_clear();
        test_reset_mid_clear();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
